aes_req_arbiter: RTL

AES_REQ_ARBITER -- requirements
Module: aes_req_arbiter

---
 rtl/aes_req_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/aes_req_arbiter.sv
// Two-requester front end for a shared AES decryption core: round-robin job
// grant, core start/wait with timeout recovery, and a held response channel.
module aes_req_arbiter #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [127:0] req_key0_i,
  input  logic [127:0] req_msg0_i,
  input  logic [127:0] req_key1_i,
  input  logic [127:0] req_msg1_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [127:0] rsp_data_o,
  output logic         rsp_err_o,
  output logic         core_start_o,
  output logic [127:0] core_key_o,
  output logic [127:0] core_msg_o,
  input  logic         core_done_i,
  input  logic [127:0] core_dec_i,
  output logic         core_reset_o,
  output logic         busy_o,
  output logic [15:0]  job_count_o,
  output logic [7:0]   err_count_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Counter holds (WAIT cycles completed - 1) while in WAIT, so the
  // TIMEOUT-th WAIT cycle is the one where it equals TIMEOUT-1.
  localparam logic [15:0] WaitLast = 16'(TIMEOUT - 1);

  state_t         state_q;
  logic           last_grant_q;
  logic [15:0]    wait_cnt_q;
  logic [15:0]    wait_cnt_d;
  logic [127:0]   key_q;
  logic [127:0]   msg_q;
  logic [127:0]   data_q;
  logic           id_q;
  logic           err_q;
  logic [15:0]    job_cnt_q;
  logic [15:0]    job_cnt_d;
  logic [7:0]     err_cnt_q;
  logic [7:0]     err_cnt_d;
  logic           core_start_q;
  logic           core_reset_q;

  logic           grant;
  logic           accept;
  logic           timeout_hit;

  always_comb begin
    grant = req_valid_i[1];
    if (req_valid_i == 2'b11) begin
      grant = ~last_grant_q;
    end
  end

  assign accept      = (state_q == IDLE) && (req_valid_i != 2'b00) && !reset_i;
  assign req_ready_o = accept ? (grant ? 2'b10 : 2'b01) : 2'b00;

  assign wait_cnt_d  = wait_cnt_q + 16'd1;
  assign timeout_hit = (wait_cnt_q == WaitLast);
  assign job_cnt_d   = job_cnt_q + 16'd1;
  assign err_cnt_d   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      wait_cnt_q   <= '0;
      key_q        <= '0;
      msg_q        <= '0;
      data_q       <= '0;
      id_q         <= 1'b0;
      err_q        <= 1'b0;
      job_cnt_q    <= '0;
      err_cnt_q    <= '0;
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      core_reset_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            key_q        <= grant ? req_key1_i : req_key0_i;
            msg_q        <= grant ? req_msg1_i : req_msg0_i;
            id_q         <= grant;
            last_grant_q <= grant;
            core_start_q <= 1'b1;
            state_q      <= START;
          end
        end
        START: begin
          wait_cnt_q <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_d;
          // Completion is checked first so a DONE on the last allowed cycle wins.
          if (core_done_i) begin
            data_q    <= core_dec_i;
            err_q     <= 1'b0;
            job_cnt_q <= job_cnt_d;
            state_q   <= RESP;
          end else if (timeout_hit) begin
            data_q       <= '0;
            err_q        <= 1'b1;
            err_cnt_q    <= err_cnt_d;
            core_reset_q <= 1'b1;
            state_q      <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = id_q;
  assign rsp_data_o   = data_q;
  assign rsp_err_o    = err_q;
  assign core_start_o = core_start_q;
  assign core_key_o   = key_q;
  assign core_msg_o   = msg_q;
  assign core_reset_o = core_reset_q;
  assign busy_o       = (state_q != IDLE);
  assign job_count_o  = job_cnt_q;
  assign err_count_o  = err_cnt_q;

endmodule
